ascon_ctrl_fsm: RTL and testbench
=================================

# ascon_ctrl_fsm

Sequencing controller for the ASCON-AEAD128 encryption datapath. It drives the round-per-cycle permutation datapath (state register, up-XOR before the round, down-XOR after it) through four phases: initialization, associated-data absorption, plaintext absorption and finalization. It accepts padded 128-bit blocks through a valid/ready handshake and produces the round index, XOR enables and operand selects, register write enable, ciphertext capture strobe and completion flag.

## Interface
Parameters:
- None; round counts and start indices are package constants.

Ports:
- clock_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start a new encryption; honoured only in IDLE
- ad_empty_i  in  1  no associated data for this message; sampled with start_i
- block_valid_i  in  1  128-bit padded block (AD or plaintext) present on the datapath input
- block_last_i  in  1  current block is the last of its phase; qualified by block_valid_i
- block_ready_o  out  1  controller can absorb a block this cycle
- init_state_o  out  1  datapath loads the initial state (IV‖K‖N) instead of the register
- en_xor_up_o  out  1  enable up-XOR before the round
- xor_up_sel_o  out  2  up operand: 0 = data into S0:S1, 1 = key into S2:S3, 2 = both
- en_xor_down_o  out  1  enable down-XOR after the round
- xor_down_sel_o  out  2  down operand: 0 = 0^64‖K into S3:S4, 1 = domain bit into S4, 2 = key and domain bit
- round_o  out  4  round index fed to constant addition
- en_reg_o  out  1  state register write enable
- en_cipher_o  out  1  capture up-XOR output rate as ciphertext
- done_o  out  1  tag valid on datapath output

## Operation
- States: IDLE, INIT, WAIT_AD, ROUND_AD, WAIT_PT, ROUND_PT, FINAL, DONE.
- Round counter: 4-bit. p12 runs indices 0..11; p8 runs 4..11. One round per cycle, en_reg_o = 1 in every round cycle.
- IDLE: all outputs 0. start_i → INIT, counter = 0, ad_empty latched.
- INIT: rounds 0..11. Round 0: init_state_o = 1. Round 11: en_xor_down_o = 1, sel = 0 (key), or 2 if latched ad_empty. After 11 → WAIT_PT if ad_empty, else WAIT_AD.
- WAIT_AD: block_ready_o = 1. On valid: this cycle is round 4 with en_xor_up_o = 1, sel 0; latch block_last_i; → ROUND_AD, counter = 5.
- ROUND_AD: rounds 5..11. Round 11 with latched last: xor_down sel 1 (domain separation). After 11 → WAIT_PT if last, else WAIT_AD.
- WAIT_PT: block_ready_o = 1. On valid, not last: round 4, xor_up sel 0, en_cipher_o = 1, → ROUND_PT. On valid and last: round 0, xor_up sel 2, en_cipher_o = 1, → FINAL, counter = 1.
- ROUND_PT: rounds 5..11 → WAIT_PT.
- FINAL: rounds 1..11. Round 11: xor_down sel 0 (tag = S3:S4 ⊕ K) → DONE.
- DONE: done_o = 1, all enables 0. Held until start_i, which behaves as in IDLE: done_o drops and INIT begins next cycle.
- Enables and selects are combinational decodes of state, counter, latched flags and block_valid_i. Selects are 0 whenever the matching enable is 0.

## Timing
- Reset: state IDLE, counter 0, latched flags 0, all outputs 0, including round_o.
- INIT: start_i at cycle 0 gives rounds 0..11 on cycles 1..12. First block_ready_o on cycle 13.
- AD or non-final PT block: 8 cycles from accept to the next block_ready_o.
- Final PT block: accept plus 11 cycles. done_o asserts the cycle after round 11.
- Ready is never asserted during ROUND_* / INIT / FINAL. block_valid_i is ignored there and the source holds the block.
- start_i outside IDLE/DONE is ignored. block_last_i without block_valid_i is ignored.
- Reset asserted mid-operation returns to IDLE asynchronously with no further register writes.

## Structure
- ascon_pack holds:
  - state enum
  - up/down select enums
  - constants ROUNDS_A = 12, ROUNDS_B = 8, RND_START_A = 0, RND_START_B = 4, RND_LAST = 11
- Sub-module round_counter:
  - inputs: load with value, increment
  - output: last flag when value = 11
- The FSM instantiates round_counter once.

## Test plan
- Reset mid-FINAL (round 6) → outputs all 0 immediately; a new start_i gives round_o = 0 with init_state_o = 1 one cycle later.
- ad_empty = 1, single PT block: start at cycle 0 → INIT round 11 on cycle 12 with xor_down_sel 2. Block accepted cycle 13 with round 0, sel 2, en_cipher_o = 1. done_o on cycle 25.
- ad_empty = 0, two AD blocks, one PT block: domain bit (sel 1) only on the second AD's round 11. AD accepts 8 cycles apart.
- Three PT blocks with valid gapped 3 cycles each: ready stays high while waiting. en_cipher_o is exactly one pulse per block. Final tag xor_down sel 0 at round 11.
- start_i pulsed during ROUND_PT and block_valid_i held during INIT → no effect on sequence or round_o.
- From DONE, start_i → done_o falls and INIT rounds 0..11 restart.

Source files
------------

// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and round constants for the ASCON-AEAD128 sequencing controller.
package ascon_pack;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_ROUND_AD,
    S_WAIT_PT,
    S_ROUND_PT,
    S_FINAL,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    UP_DATA = 2'd0,
    UP_KEY  = 2'd1,
    UP_BOTH = 2'd2
  } up_sel_e;

  typedef enum logic [1:0] {
    DN_KEY        = 2'd0,
    DN_DOMAIN     = 2'd1,
    DN_KEY_DOMAIN = 2'd2
  } down_sel_e;

  localparam int         ROUNDS_A    = 12;
  localparam int         ROUNDS_B    = 8;
  localparam logic [3:0] RND_START_A = 4'd0;
  // p8 is the tail of p12, so both permutations end on the same index.
  localparam logic [3:0] RND_START_B = 4'(ROUNDS_A - ROUNDS_B);
  localparam logic [3:0] RND_LAST    = 4'(ROUNDS_A - 1);

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the block source and the controller.
interface ascon_ctrl_fsm_if;
  logic       start_i;
  logic       ad_empty_i;
  logic       block_valid_i;
  logic       block_last_i;
  logic       block_ready_o;
  logic       init_state_o;
  logic       en_xor_up_o;
  logic [1:0] xor_up_sel_o;
  logic       en_xor_down_o;
  logic [1:0] xor_down_sel_o;
  logic [3:0] round_o;
  logic       en_reg_o;
  logic       en_cipher_o;
  logic       done_o;

  modport slave (
    input  start_i, ad_empty_i, block_valid_i, block_last_i,
    output block_ready_o, init_state_o, en_xor_up_o, xor_up_sel_o,
           en_xor_down_o, xor_down_sel_o, round_o, en_reg_o, en_cipher_o, done_o
  );

  modport master (
    output start_i, ad_empty_i, block_valid_i, block_last_i,
    input  block_ready_o, init_state_o, en_xor_up_o, xor_up_sel_o,
           en_xor_down_o, xor_down_sel_o, round_o, en_reg_o, en_cipher_o, done_o
  );
endinterface

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// 4-bit round index with parallel load; flags the final round of any permutation.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] value_o,
  output logic       last_o
);
  logic [3:0] cnt_q;

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign value_o = cnt_q;
  assign last_o  = (cnt_q == RND_LAST);
endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-AEAD128 encryption sequencer: walks the round-per-cycle datapath through
// init, AD absorption, plaintext absorption and finalization.
module ascon_ctrl_fsm
  import ascon_pack::*;
(
  input logic             clock_i,
  input logic             rst_i,
  ascon_ctrl_fsm_if.slave bus
);
  state_e     state_q;
  logic       ad_empty_q;
  logic       last_q;

  logic       cnt_load, cnt_inc, cnt_last;
  logic [3:0] cnt_load_val, cnt_value;

  logic       block_ready, init_state, en_xor_up, en_xor_down, en_reg, en_cipher, done;
  logic [1:0] xor_up_sel, xor_down_sel;
  logic [3:0] round;

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .value_o    (cnt_value),
    .last_o     (cnt_last)
  );

  // Accept cycles run the first round of the block directly, so decodes see block_valid_i.
  always_comb begin
    block_ready  = 1'b0;
    init_state   = 1'b0;
    en_xor_up    = 1'b0;
    xor_up_sel   = UP_DATA;
    en_xor_down  = 1'b0;
    xor_down_sel = DN_KEY;
    round        = 4'd0;
    en_reg       = 1'b0;
    en_cipher    = 1'b0;
    done         = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = RND_START_A;
    cnt_inc      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done     = (state_q == S_DONE);
        cnt_load = bus.start_i;
      end
      S_INIT: begin
        en_reg     = 1'b1;
        round      = cnt_value;
        init_state = (cnt_value == RND_START_A);
        cnt_inc    = !cnt_last;
        if (cnt_last) begin
          en_xor_down  = 1'b1;
          xor_down_sel = ad_empty_q ? DN_KEY_DOMAIN : DN_KEY;
        end
      end
      S_WAIT_AD: begin
        block_ready = 1'b1;
        if (bus.block_valid_i) begin
          en_reg       = 1'b1;
          round        = RND_START_B;
          en_xor_up    = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = RND_START_B + 4'd1;
        end
      end
      S_ROUND_AD: begin
        en_reg  = 1'b1;
        round   = cnt_value;
        cnt_inc = !cnt_last;
        if (cnt_last && last_q) begin
          en_xor_down  = 1'b1;
          xor_down_sel = DN_DOMAIN;
        end
      end
      S_WAIT_PT: begin
        block_ready = 1'b1;
        if (bus.block_valid_i) begin
          en_reg    = 1'b1;
          en_xor_up = 1'b1;
          en_cipher = 1'b1;
          cnt_load  = 1'b1;
          if (bus.block_last_i) begin
            round        = RND_START_A;
            xor_up_sel   = UP_BOTH;
            cnt_load_val = RND_START_A + 4'd1;
          end else begin
            round        = RND_START_B;
            cnt_load_val = RND_START_B + 4'd1;
          end
        end
      end
      S_ROUND_PT: begin
        en_reg  = 1'b1;
        round   = cnt_value;
        cnt_inc = !cnt_last;
      end
      S_FINAL: begin
        en_reg      = 1'b1;
        round       = cnt_value;
        cnt_inc     = !cnt_last;
        en_xor_down = cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ad_empty_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            state_q    <= S_INIT;
            ad_empty_q <= bus.ad_empty_i;
            last_q     <= 1'b0;
          end
        end
        S_INIT:     if (cnt_last) state_q <= ad_empty_q ? S_WAIT_PT : S_WAIT_AD;
        S_WAIT_AD: begin
          if (bus.block_valid_i) begin
            last_q  <= bus.block_last_i;
            state_q <= S_ROUND_AD;
          end
        end
        S_ROUND_AD: if (cnt_last) state_q <= last_q ? S_WAIT_PT : S_WAIT_AD;
        S_WAIT_PT:  if (bus.block_valid_i) state_q <= bus.block_last_i ? S_FINAL : S_ROUND_PT;
        S_ROUND_PT: if (cnt_last) state_q <= S_WAIT_PT;
        S_FINAL:    if (cnt_last) state_q <= S_DONE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.block_ready_o  = block_ready;
  assign bus.init_state_o   = init_state;
  assign bus.en_xor_up_o    = en_xor_up;
  assign bus.xor_up_sel_o   = xor_up_sel;
  assign bus.en_xor_down_o  = en_xor_down;
  assign bus.xor_down_sel_o = xor_down_sel;
  assign bus.round_o        = round;
  assign bus.en_reg_o       = en_reg;
  assign bus.en_cipher_o    = en_cipher;
  assign bus.done_o         = done;
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench: the message-level model queues per-cycle expected outputs,
// and a negedge monitor pops and compares whenever the controller shows activity.
module tb_ascon_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  ascon_ctrl_fsm_if bus ();

  ascon_ctrl_fsm dut (
    .clock_i (clk),
    .rst_i   (rst_i),
    .bus     (bus)
  );

  typedef struct packed {
    int          cyc;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  bit   in_done = 1'b0;

  logic [14:0] dut_vec;
  assign dut_vec = {bus.block_ready_o, bus.init_state_o, bus.en_xor_up_o, bus.xor_up_sel_o,
                    bus.en_xor_down_o, bus.xor_down_sel_o, bus.round_o, bus.en_reg_o,
                    bus.en_cipher_o, bus.done_o};

  // Field order: ready, init, up, up_sel, down, down_sel, round, en_reg, cipher, done
  function automatic logic [14:0] mk(bit rdy, bit init, bit up, logic [1:0] us, bit dn,
                                     logic [1:0] ds, logic [3:0] rnd, bit rg, bit ci, bit dne);
    return {rdy, init, up, us, dn, ds, rnd, rg, ci, dne};
  endfunction

  function automatic logic [14:0] rnd_vec(int r);
    return mk(0, 0, 0, 2'd0, 0, 2'd0, 4'(r), 1, 0, 0);
  endfunction

  localparam logic [14:0] DONE_V = 15'd1;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick(input logic [14:0] e);
    if (e != '0) exp_q.push_back('{cyc, e});
    step();
  endtask

  task automatic junk();
    bus.start_i       = ($urandom % 6 == 0);
    bus.block_valid_i = 1'($urandom);
    bus.block_last_i  = 1'($urandom);
    bus.ad_empty_i    = 1'($urandom);
  endtask

  task automatic quiet();
    junk();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_phase(input int gap);
    for (int g = 0; g < gap; g++) begin
      junk();
      bus.block_valid_i = 1'b0;
      tick(mk(1, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0));
    end
    junk();
    bus.block_valid_i = 1'b1;
  endtask

  task automatic run_msg(input bit ae, input int n_ad, input int n_pt, input int gap_fix,
                         input bit abort);
    int gap;
    bit last;
    $display("msg: ad_empty=%0d ad_blocks=%0d pt_blocks=%0d abort=%0d at cycle %0d",
             ae, n_ad, n_pt, abort, cyc);
    quiet();
    bus.start_i    = 1'b1;
    bus.ad_empty_i = ae;
    tick(in_done ? DONE_V : 15'd0);
    in_done = 1'b0;
    // p12 init; the source holds a block on valid throughout, which must be ignored
    for (int r = 0; r < 12; r++) begin
      junk();
      bus.block_valid_i = 1'b1;
      tick(mk(0, r == 0, 0, 2'd0, r == 11, (r == 11) ? (ae ? 2'd2 : 2'd0) : 2'd0,
              4'(r), 1, 0, 0));
    end
    for (int b = 0; b < n_ad; b++) begin
      gap  = (gap_fix >= 0) ? gap_fix : int'($urandom % 4);
      last = (b == n_ad - 1);
      wait_phase(gap);
      bus.block_last_i = last;
      tick(mk(1, 0, 1, 2'd0, 0, 2'd0, 4'd4, 1, 0, 0));
      for (int r = 5; r < 12; r++) begin
        junk();
        tick(mk(0, 0, 0, 2'd0, last && r == 11, (last && r == 11) ? 2'd1 : 2'd0,
                4'(r), 1, 0, 0));
      end
    end
    for (int b = 0; b < n_pt; b++) begin
      gap  = (gap_fix >= 0) ? gap_fix : int'($urandom % 4);
      last = (b == n_pt - 1);
      wait_phase(gap);
      bus.block_last_i = last;
      if (!last) begin
        tick(mk(1, 0, 1, 2'd0, 0, 2'd0, 4'd4, 1, 1, 0));
        for (int r = 5; r < 12; r++) begin
          junk();
          if (r == 7) bus.start_i = 1'b1;
          tick(rnd_vec(r));
        end
      end else begin
        tick(mk(1, 0, 1, 2'd2, 0, 2'd0, 4'd0, 1, 1, 0));
        for (int r = 1; r < 12; r++) begin
          junk();
          if (abort && r == 6) begin
            bus.start_i = 1'b0;
            exp_q.push_back('{cyc, rnd_vec(r)});
            @(negedge clk);
            #2;
            rst_i = 1'b1;
            #1;
            n_check++;
            if (dut_vec !== 15'd0) begin
              n_fail++;
              $display("FAIL async_reset_outputs got=%h want=0000", dut_vec);
            end
            @(posedge clk);
            #1;
            cyc++;
            rst_i = 1'b0;
            quiet();
            tick(15'd0);
            quiet();
            tick(15'd0);
            return;
          end
          tick(mk(0, 0, 0, 2'd0, r == 11, 2'd0, 4'(r), 1, 0, 0));
        end
      end
    end
    in_done = 1'b1;
    for (int k = 0; k < int'($urandom % 3); k++) begin
      quiet();
      tick(DONE_V);
    end
  endtask

  // Monitor: one comparison per active cycle or per cycle the model expects activity.
  initial begin
    exp_t e;
    bit   has;
    forever begin
      @(negedge clk);
      has = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (dut_vec != 15'd0 || has) begin
        n_check++;
        if (!has) begin
          n_fail++;
          $display("FAIL unexpected_output cycle=%0d got=%h want=0000", cyc, dut_vec);
        end else begin
          e = exp_q.pop_front();
          if (dut_vec !== e.v) begin
            n_fail++;
            $display("FAIL cycle_outputs cycle=%0d got=%h want=%h", cyc, dut_vec, e.v);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i       = 1'b0;
    bus.ad_empty_i    = 1'b0;
    bus.block_valid_i = 1'b0;
    bus.block_last_i  = 1'b0;
    rst_i             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_check++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0000", dut_vec);
    end
    rst_i = 1'b0;
    cyc   = 0;
    quiet();
    tick(15'd0);

    run_msg(1'b1, 0, 1, 0, 1'b0);
    run_msg(1'b0, 2, 1, -1, 1'b0);
    run_msg(1'b1, 0, 3, 3, 1'b0);
    for (int m = 0; m < 10; m++) begin
      bit ae;
      ae = 1'($urandom);
      run_msg(ae, ae ? 0 : 1 + int'($urandom % 3), 1 + int'($urandom % 3), -1, 1'b0);
    end
    run_msg(1'b0, 1, 1, -1, 1'b1);
    run_msg(1'b1, 0, 1, 0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      quiet();
      tick(in_done ? DONE_V : 15'd0);
    end
    n_check++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end
endmodule
